// File: rtl/matvec_ctrl.sv
// Control FSM and address sequencer for the matrix-vector multiply datapath.
// Loads M*N matrix words (row-major) and N vector words from the input stream,
// then walks each row through the memories, steers the accumulator, and
// presents one result per row on the output stream. Holds no data itself.
module matvec_ctrl #(
  parameter int M      = 3,
  parameter int N      = 3,
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   input_valid,
  output logic                   input_ready,
  output logic                   output_valid,
  input  logic                   output_ready,
  output logic [$clog2(M*N)-1:0] m_addr,
  output logic                   m_wr_en,
  output logic [$clog2(N)-1:0]   x_addr,
  output logic                   x_wr_en,
  output logic                   acc_en,
  output logic                   acc_clear
);

  localparam int MW = $clog2(M*N);
  localparam int XW = $clog2(N);
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [MW-1:0] MAT_LAST   = MW'(M*N-1);
  localparam logic [MW-1:0] VEC_LAST   = MW'(N-1);
  localparam logic [XW-1:0] COL_LAST   = XW'(N-1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(M-1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(RD_LAT-1);

  typedef enum logic [2:0] {
    LOAD_M,
    LOAD_X,
    ISSUE,
    DRAIN,
    OUT
  } state_e;

  state_e            state_q, state_d;
  logic [MW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     row_q, row_d;
  logic [XW-1:0]     col_q, col_d;
  logic [DW-1:0]     drn_q, drn_d;
  logic [RD_LAT-1:0] iss_pipe_q;
  logic [RD_LAT-1:0] clr_pipe_q;
  logic              issue;
  logic              issue_first;
  logic              accept;

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOAD_M;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      drn_q   <= drn_d;
    end
  end

  // Delay the issue flags by the memory read latency so the accumulator
  // enables line up with the data arriving at the MAC input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iss_pipe_q <= '0;
      clr_pipe_q <= '0;
    end else begin
      iss_pipe_q <= RD_LAT'({iss_pipe_q, issue});
      clr_pipe_q <= RD_LAT'({clr_pipe_q, issue_first});
    end
  end

  assign acc_en    = iss_pipe_q[RD_LAT-1];
  assign acc_clear = clr_pipe_q[RD_LAT-1];

  // Next-state, counter updates and state-gated strobes/addresses.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    row_d        = row_q;
    col_d        = col_q;
    drn_d        = drn_q;
    input_ready  = 1'b0;
    output_valid = 1'b0;
    m_addr       = '0;
    m_wr_en      = 1'b0;
    x_addr       = '0;
    x_wr_en      = 1'b0;
    issue        = 1'b0;
    issue_first  = 1'b0;
    accept       = 1'b0;

    case (state_q)
      LOAD_M: begin
        input_ready = ~reset;
        accept      = input_valid & input_ready;
        m_addr      = cnt_q;
        m_wr_en     = accept;
        if (accept) begin
          if (cnt_q == MAT_LAST) begin
            state_d = LOAD_X;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + MW'(1);
          end
        end
      end

      LOAD_X: begin
        input_ready = ~reset;
        accept      = input_valid & input_ready;
        x_addr      = cnt_q[XW-1:0];
        x_wr_en     = accept;
        if (accept) begin
          if (cnt_q == VEC_LAST) begin
            state_d = ISSUE;
            cnt_d   = '0;
            row_d   = '0;
            col_d   = '0;
          end else begin
            cnt_d = cnt_q + MW'(1);
          end
        end
      end

      ISSUE: begin
        issue       = 1'b1;
        issue_first = (col_q == '0);
        m_addr      = MW'(row_q) * MW'(N) + MW'(col_q);
        x_addr      = col_q;
        if (col_q == COL_LAST) begin
          state_d = DRAIN;
          drn_d   = '0;
        end else begin
          col_d = col_q + XW'(1);
        end
      end

      DRAIN: begin
        if (drn_q == DRAIN_LAST) begin
          state_d = OUT;
        end else begin
          drn_d = drn_q + DW'(1);
        end
      end

      OUT: begin
        output_valid = 1'b1;
        if (output_ready) begin
          if (row_q == ROW_LAST) begin
            state_d = LOAD_M;
            cnt_d   = '0;
            row_d   = '0;
          end else begin
            state_d = ISSUE;
            row_d   = row_q + RW'(1);
            col_d   = '0;
          end
        end
      end

      default: begin
        state_d = LOAD_M;
        cnt_d   = '0;
        row_d   = '0;
        col_d   = '0;
        drn_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_matvec_ctrl.sv
// Bench for matvec_ctrl: one instance at RD_LAT=1 and one at RD_LAT=2, each
// with a behavioural timeline model and a small memory/MAC datapath driven by
// the controller's strobes, so results are checked end to end.
module tb_matvec_ctrl;

  localparam int M  = 3;
  localparam int N  = 3;
  localparam int MN = M * N;
  localparam int NW = MN + N;

  logic clk = 1'b0;
  logic rst  [2];
  logic iv   [2];
  logic ordy [2];
  logic ir   [2];
  logic ov   [2];
  logic mwe  [2];
  logic xwe  [2];
  logic ae   [2];
  logic ac   [2];
  logic [3:0] ma [2];
  logic [1:0] xa [2];
  logic signed [13:0] din [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  matvec_ctrl #(.M(M), .N(N), .RD_LAT(1)) dut0 (
    .clk(clk), .reset(rst[0]), .input_valid(iv[0]), .input_ready(ir[0]),
    .output_valid(ov[0]), .output_ready(ordy[0]), .m_addr(ma[0]), .m_wr_en(mwe[0]),
    .x_addr(xa[0]), .x_wr_en(xwe[0]), .acc_en(ae[0]), .acc_clear(ac[0])
  );

  matvec_ctrl #(.M(M), .N(N), .RD_LAT(2)) dut1 (
    .clk(clk), .reset(rst[1]), .input_valid(iv[1]), .input_ready(ir[1]),
    .output_valid(ov[1]), .output_ready(ordy[1]), .m_addr(ma[1]), .m_wr_en(mwe[1]),
    .x_addr(xa[1]), .x_wr_en(xwe[1]), .acc_en(ae[1]), .acc_clear(ac[1])
  );

  // Model state: words accepted so far, or (row, cycles since row issue began).
  bit     comp   [2];
  int     loaded [2];
  int     row    [2];
  int     t      [2];
  longint words  [2][NW];
  // Datapath: memories, read-address history, accumulator, captured results.
  longint mat    [2][MN];
  longint vec    [2][N];
  int     mh     [2][2];
  int     xh     [2][2];
  longint acc    [2];
  longint res    [2][M];
  int     mwe_cnt[2];
  int     xwe_cnt[2];

  longint plan [NW] = '{10, -20, 30, 50, -60, 70, 80, 100, -110, 40, 30, -20};

  function automatic int rdl(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic longint dotp(input int k, input int r);
    longint s = 0;
    for (int j = 0; j < N; j++) s += words[k][r*N + j] * words[k][MN + j];
    return s;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Per-cycle compare against the timeline model, then advance model and datapath.
  always @(negedge clk) begin
    int r, e_ma, e_xa, mi, xi;
    bit e_ir, e_ov, e_mwe, e_xwe, e_ae, e_ac;
    longint p;
    for (int k = 0; k < 2; k++) begin
      r = rdl(k);
      e_ir = 0; e_ov = 0; e_mwe = 0; e_xwe = 0; e_ae = 0; e_ac = 0;
      e_ma = 0; e_xa = 0;
      if (!rst[k]) begin
        if (!comp[k]) begin
          e_ir = 1;
          if (loaded[k] < MN) begin
            e_ma = loaded[k]; e_mwe = iv[k];
          end else begin
            e_xa = loaded[k] - MN; e_xwe = iv[k];
          end
        end else begin
          if (t[k] < N) begin
            e_ma = row[k] * N + t[k]; e_xa = t[k];
          end
          e_ae = (t[k] >= r) && (t[k] < N + r);
          e_ac = (t[k] == r);
          e_ov = (t[k] >= N + r);
        end
      end
      chk($sformatf("dut%0d.input_ready", k),  ir[k],  e_ir);
      chk($sformatf("dut%0d.output_valid", k), ov[k],  e_ov);
      chk($sformatf("dut%0d.m_addr", k),       ma[k],  e_ma);
      chk($sformatf("dut%0d.m_wr_en", k),      mwe[k], e_mwe);
      chk($sformatf("dut%0d.x_addr", k),       xa[k],  e_xa);
      chk($sformatf("dut%0d.x_wr_en", k),      xwe[k], e_xwe);
      chk($sformatf("dut%0d.acc_en", k),       ae[k],  e_ae);
      chk($sformatf("dut%0d.acc_clear", k),    ac[k],  e_ac);

      if (rst[k]) begin
        comp[k] = 0; loaded[k] = 0; row[k] = 0; t[k] = 0; acc[k] = 0;
        mh[k][0] = 0; mh[k][1] = 0; xh[k][0] = 0; xh[k][1] = 0;
      end else begin
        if (mwe[k]) begin
          if (int'(ma[k]) < MN) mat[k][ma[k]] = din[k];
          mwe_cnt[k]++;
        end
        if (xwe[k]) begin
          if (int'(xa[k]) < N) vec[k][xa[k]] = din[k];
          xwe_cnt[k]++;
        end
        if (ae[k]) begin
          mi = mh[k][r-1]; xi = xh[k][r-1];
          p = (mi < MN && xi < N) ? mat[k][mi] * vec[k][xi] : 0;
          acc[k] = ac[k] ? p : acc[k] + p;
        end
        mh[k][1] = mh[k][0]; mh[k][0] = int'(ma[k]);
        xh[k][1] = xh[k][0]; xh[k][0] = int'(xa[k]);
        if (e_ov && ordy[k]) begin
          res[k][row[k]] = acc[k];
          chk($sformatf("dut%0d.result row%0d", k, row[k]), acc[k], dotp(k, row[k]));
        end
        if (!comp[k]) begin
          if (iv[k]) begin
            words[k][loaded[k]] = din[k];
            loaded[k]++;
            if (loaded[k] == NW) begin
              comp[k] = 1; row[k] = 0; t[k] = 0;
            end
          end
        end else if (t[k] < N + r) begin
          t[k]++;
        end else if (ordy[k]) begin
          row[k]++;
          if (row[k] == M) begin
            comp[k] = 0; loaded[k] = 0; row[k] = 0;
          end else begin
            t[k] = 0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int k, input int dens, input bit dir);
    int n = 0;
    int guard = 0;
    while (n < NW && guard < 400) begin
      iv[k]   = (dens >= 100) ? 1'b1 : 1'($urandom_range(99) < dens);
      din[k]  = dir ? 14'(plan[n]) : 14'($urandom_range(16383));
      ordy[k] = 1'($urandom_range(1));
      if (iv[k] && ir[k]) n++;
      step();
      guard++;
    end
    iv[k] = 1'b0;
    ordy[k] = 1'b0;
    if (n < NW) chk($sformatf("dut%0d load words", k), n, NW);
  endtask

  task automatic drain_out(input int k, input int stall, input bit rnd, output int lat);
    int c, s;
    lat = -1;
    for (int rr = 0; rr < M; rr++) begin
      c = 0;
      while (!ov[k] && c < 50) begin
        ordy[k] = 1'($urandom_range(1));
        iv[k]   = 1'($urandom_range(1));
        step();
        c++;
      end
      ordy[k] = 1'b0;
      if (rr == 0) lat = c;
      if (!ov[k]) begin
        chk($sformatf("dut%0d output_valid wait", k), ov[k], 1);
        iv[k] = 1'b0;
        return;
      end
      iv[k] = 1'($urandom_range(1));
      s = rnd ? int'($urandom_range(3)) : stall;
      repeat (s) step();
      ordy[k] = 1'b1;
      step();
      ordy[k] = 1'b0;
      iv[k]   = 1'b0;
    end
  endtask

  task automatic check_plan_results(input int k);
    chk($sformatf("dut%0d plan row0", k), res[k][0], -800);
    chk($sformatf("dut%0d plan row1", k), res[k][1], -1200);
    chk($sformatf("dut%0d plan row2", k), res[k][2], 8400);
  endtask

  initial begin
    int lat, m0, x0, c;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; iv[k] = 1'b0; ordy[k] = 1'b0; din[k] = '0;
    end
    repeat (3) step();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    step();

    // Directed load and compute with the reference vectors, 5-cycle output stall.
    for (int k = 0; k < 2; k++) begin
      m0 = mwe_cnt[k];
      x0 = xwe_cnt[k];
      load(k, 100, 1'b1);
      chk($sformatf("dut%0d matrix writes", k), mwe_cnt[k] - m0, 9);
      chk($sformatf("dut%0d vector writes", k), xwe_cnt[k] - x0, 3);
      drain_out(k, 5, 1'b0, lat);
      chk($sformatf("dut%0d first result latency", k), lat, (k == 0) ? 4 : 5);
      check_plan_results(k);
      repeat (100) step();
    end

    // Random data, sparse input_valid, random output stalls.
    repeat (6) begin
      for (int k = 0; k < 2; k++) begin
        load(k, 60, 1'b0);
        drain_out(k, 0, 1'b1, lat);
        chk($sformatf("dut%0d random latency", k), lat, (k == 0) ? 4 : 5);
      end
    end

    // Reset during row 1 issue, then a clean full run.
    for (int k = 0; k < 2; k++) begin
      load(k, 100, 1'b0);
      c = 0;
      while (!ov[k] && c < 50) begin
        step();
        c++;
      end
      chk($sformatf("dut%0d row0 ready before reset", k), ov[k], 1);
      ordy[k] = 1'b1;
      step();
      ordy[k] = 1'b0;
      step();
      rst[k] = 1'b1;
      #1;
      chk($sformatf("dut%0d m_addr in reset", k), ma[k], 0);
      chk($sformatf("dut%0d input_ready in reset", k), ir[k], 0);
      step();
      step();
      rst[k] = 1'b0;
      step();
      load(k, 100, 1'b1);
      drain_out(k, 2, 1'b0, lat);
      check_plan_results(k);
    end

    repeat (5) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
    $fatal(1);
  end

endmodule
